clk_freq_monitor: RTL and testbench
===================================

CLK_FREQ_MONITOR -- requirements
Module: clk_freq_monitor

Interface
REQ-001 SHALL have parameter EXP_PERIOD, default 500000, expected clk_in period in clk_50MHz cycles (100 Hz).
REQ-002 SHALL have parameter TOL, default 500, allowed +/- deviation in cycles.
REQ-003 SHALL have parameter CNT_W, default 21, counter/output width; must hold 2*EXP_PERIOD.
REQ-004 SHALL have port clk_50MHz, input, 1, sole clock.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port clk_in, input, 1, monitored slow clock, asynchronous to clk_50MHz.
REQ-007 SHALL have port period_cnt, output, CNT_W, last measured period in clk_50MHz cycles.
REQ-008 SHALL have port period_valid, output, 1, one-cycle pulse when period_cnt updates.
REQ-009 SHALL have port freq_ok, output, 1, last period within EXP_PERIOD +/- TOL and clock present.
REQ-010 SHALL have port freq_err, output, 1, sticky error flag.
REQ-011 SHALL have port clk_lost, output, 1, no clk_in rising edge for 2*EXP_PERIOD cycles.

Function
REQ-012 SHALL synchronize clk_in through two flops, then detect rising edge (rise) as sync output 0 -> 1; rise SHALL assert 3 clk_50MHz cycles after a clk_in edge, constant latency.
REQ-013 SHALL implement FSM states IDLE, MEASURE, LOST.
REQ-014 In IDLE, rise SHALL load count=1 and go to MEASURE; no period_valid on this first edge.
REQ-015 In MEASURE, count SHALL increment by 1 each cycle without rise.
REQ-016 In MEASURE, on rise: period_cnt <= count, period_valid=1 next cycle, count <= 1; an N-cycle clk_in period SHALL yield period_cnt = N.
REQ-017 On period_valid, freq_ok SHALL be 1 iff EXP_PERIOD-TOL <= period_cnt <= EXP_PERIOD+TOL (unsigned compare, no underflow: lower bound clamps at 0).
REQ-018 An out-of-window period SHALL set freq_err and clear freq_ok on the same cycle as period_valid.
REQ-019 In MEASURE or IDLE, when count (or idle cycles) reaches 2*EXP_PERIOD without rise: go to LOST, clk_lost=1, freq_ok=0, freq_err=1; count SHALL saturate, never wrap.
REQ-020 Rise and timeout in same cycle: rise SHALL win (normal measurement, no LOST).
REQ-021 In LOST, rise SHALL clear clk_lost, load count=1, go to MEASURE; first period_valid after recovery SHALL come on the following rise.
REQ-022 freq_err SHALL clear only on reset.

Reset
REQ-023 Reset SHALL force state IDLE, count=0, sync flops=0, period_cnt=0, period_valid=0, freq_ok=0, freq_err=0, clk_lost=0.
REQ-024 Reset mid-measurement SHALL discard the partial count; no period_valid SHALL be produced from pre-reset edges.

Configuration
REQ-025 Macro CLK_MON_DUTY_EN defined: SHALL add output high_cnt (CNT_W), clk_50MHz cycles synced clk_in was high in last period, updated with period_valid; high count restarts on rise, saturates like count.
REQ-026 Macro undefined: high_cnt port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package clk_mon_pkg SHALL hold the FSM state enum (IDLE, MEASURE, LOST) and default constants (EXP_PERIOD, TOL, CNT_W).
REQ-028 Sub-module sync_edge_det SHALL contain the two-flop synchronizer plus rising-edge detector, with clk_50MHz, reset, async input, rise output.

Verification (EXP_PERIOD=100, TOL=2, CNT_W=9, clk_50MHz period 20 ns)
REQ-029 clk_in period 2000 ns, 5 periods -> period_cnt=100 each period_valid, freq_ok=1, freq_err=0.
REQ-030 clk_in period 2100 ns -> period_cnt=105, freq_ok=0, freq_err=1 and stays 1 after returning to 2000 ns.
REQ-031 clk_in held low after one period -> clk_lost=1 exactly 200 cycles after last rise, freq_ok=0; restart clk_in -> clk_lost=0 on first rise, period_valid on second.
REQ-032 Reset asserted at mid-period (count=50) -> all outputs 0 next cycle, no period_valid until two rises after release.
REQ-033 Boundary: period 98 and 102 cycles -> freq_ok=1; 97 and 103 cycles -> freq_ok=0.
REQ-034 With CLK_MON_DUTY_EN, clk_in high 600 ns / low 1400 ns -> high_cnt=30, period_cnt=100.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the clk_in frequency monitor.
package clk_mon_pkg;

  localparam int DEF_EXP_PERIOD = 500000;
  localparam int DEF_TOL        = 500;
  localparam int DEF_CNT_W      = 21;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } mon_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus registered rising-edge detector for an async input.
// With CLK_MON_DUTY_EN defined, also exports the synced level aligned to rise.
module sync_edge_det (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic async_in,
`ifdef CLK_MON_DUTY_EN
  output logic level,
`endif
  output logic rise
);

  logic s1_q, s2_q, s3_q, rise_q;

  // rise_q and s3_q change on the same edge, so level is 1 in the rise cycle
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= async_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  assign rise = rise_q;
`ifdef CLK_MON_DUTY_EN
  assign level = s3_q;
`endif

endmodule

// File: rtl/clk_freq_monitor.sv
// Measures clk_in period in clk_50MHz cycles, flags out-of-window and lost clocks.
// Optional CLK_MON_DUTY_EN adds high_cnt (synced high-time of the last period).
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic             period_valid,
  output logic             freq_ok,
  output logic             freq_err,
`ifdef CLK_MON_DUTY_EN
  output logic [CNT_W-1:0] high_cnt,
`endif
  output logic             clk_lost
);

  localparam logic [CNT_W-1:0] LIM    = CNT_W'(2 * EXP_PERIOD);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(2 * EXP_PERIOD - 1);
  localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W:0]   EXP_X  = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_X  = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  mon_state_e       state_q;
  logic [CNT_W-1:0] count_q, period_q;
  logic             pvld_q, ok_q, err_q, lost_q;
  logic             rise, timeout, in_win;

`ifdef CLK_MON_DUTY_EN
  logic             lvl;
  logic [CNT_W-1:0] hacc_q, hcnt_q;
`endif

  sync_edge_det u_sync (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .async_in  (clk_in),
`ifdef CLK_MON_DUTY_EN
    .level     (lvl),
`endif
    .rise      (rise)
  );

  assign timeout = (count_q >= LIM_M1);
  // count+TOL >= EXP is the lower bound without underflow when TOL > EXP
  assign in_win  = (({1'b0, count_q} + TOL_X) >= EXP_X) && (count_q <= WIN_HI);

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      pvld_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      pvld_q <= 1'b0;
      case (state_q)
        IDLE, MEASURE: begin
          if (rise) begin
            count_q <= ONE;
            state_q <= MEASURE;
            if (state_q == MEASURE) begin
              period_q <= count_q;
              pvld_q   <= 1'b1;
              ok_q     <= in_win;
              if (!in_win) err_q <= 1'b1;
            end
          end else if (timeout) begin
            count_q <= LIM;
            lost_q  <= 1'b1;
            ok_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= LOST;
          end else begin
            count_q <= count_q + ONE;
          end
        end
        LOST: begin
          if (rise) begin
            lost_q  <= 1'b0;
            count_q <= ONE;
            state_q <= MEASURE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CLK_MON_DUTY_EN
  // Accumulator window starts on the rise cycle, matching count_q
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      hacc_q <= '0;
      hcnt_q <= '0;
    end else begin
      if (rise) hacc_q <= {{(CNT_W-1){1'b0}}, lvl};
      else if (lvl && hacc_q < LIM) hacc_q <= hacc_q + ONE;
      if (rise && state_q == MEASURE) hcnt_q <= hacc_q;
    end
  end
  assign high_cnt = hcnt_q;
`endif

  assign period_cnt   = period_q;
  assign period_valid = pvld_q;
  assign freq_ok      = ok_q;
  assign freq_err     = err_q;
  assign clk_lost     = lost_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor (EXP_PERIOD=100, TOL=2, CNT_W=9, 20 ns clock).
module tb_clk_freq_monitor;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         reset, clk_in;
  logic [W-1:0] period_cnt;
  logic         period_valid, freq_ok, freq_err, clk_lost;
`ifdef CLK_MON_DUTY_EN
  logic [W-1:0] high_cnt;
`endif

  int compared = 0, mismatched = 0;
  int pv_total = 0, last_pc = 0, last_ok = 0, last_err = 0, last_hc = 0;
  int base;

  always #10 clk = ~clk;

  clk_freq_monitor #(.EXP_PERIOD(100), .TOL(2), .CNT_W(W)) dut (
    .clk_50MHz    (clk),
    .reset        (reset),
    .clk_in       (clk_in),
    .period_cnt   (period_cnt),
    .period_valid (period_valid),
    .freq_ok      (freq_ok),
    .freq_err     (freq_err),
`ifdef CLK_MON_DUTY_EN
    .high_cnt     (high_cnt),
`endif
    .clk_lost     (clk_lost)
  );

  // Record what the DUT reported at each period_valid pulse
  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      pv_total = pv_total + 1;
      last_pc  = int'(period_cnt);
      last_ok  = int'(freq_ok);
      last_err = int'(freq_err);
`ifdef CLK_MON_DUTY_EN
      last_hc  = int'(high_cnt);
`endif
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clk_in period: rise now, high h cycles, low l cycles
  task automatic gen(input int h, input int l);
    clk_in = 1'b1;
    repeat (h) @(negedge clk);
    clk_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  // Period h+l is reported on the rise that starts the following period
  task automatic meas(input string tag, input int h, input int l,
                      input int exp_ok, input int exp_err);
    gen(h, l);
    gen(50, 50);
    chk({tag, "_cnt"}, last_pc, h + l);
    chk({tag, "_ok"},  last_ok, exp_ok);
    chk({tag, "_err"}, last_err, exp_err);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pcnt"},  int'(period_cnt), 0);
    chk({tag, "_pvld"},  int'(period_valid), 0);
    chk({tag, "_ok"},    int'(freq_ok), 0);
    chk({tag, "_err"},   int'(freq_err), 0);
    chk({tag, "_lost"},  int'(clk_lost), 0);
  endtask

  initial begin
    reset  = 1'b1;
    clk_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;

    // Nominal 100-cycle clock: six rises give five measurements
    base = pv_total;
    for (int i = 0; i < 6; i++) begin
      gen(50, 50);
      if (i > 0) chk("nom_cnt", last_pc, 100);
    end
    chk("nom_pv", pv_total - base, 5);
    chk("nom_ok", last_ok, 1);
    chk("nom_err", int'(freq_err), 0);

    // Window edges, then out-of-window periods
    meas("p98",  49, 49, 1, 0);
    meas("p102", 51, 51, 1, 0);
    meas("p97",  48, 49, 0, 1);
    meas("p103", 52, 51, 0, 1);
    meas("p105", 52, 53, 0, 1);
    gen(50, 50);
    gen(50, 50);
    chk("back_cnt", last_pc, 100);
    chk("back_ok", last_ok, 1);
    chk("back_err", int'(freq_err), 1);

    // Clock lost: rise at negedge N0, lost must appear between N202 and N203
    clk_in = 1'b1;
    repeat (50) @(negedge clk);
    clk_in = 1'b0;
    repeat (152) @(negedge clk);
    chk("lost_early", int'(clk_lost), 0);
    @(negedge clk);
    chk("lost_set", int'(clk_lost), 1);
    chk("lost_ok", int'(freq_ok), 0);
    chk("lost_err", int'(freq_err), 1);
    base = pv_total;
    repeat (300) @(negedge clk);
    chk("lost_hold", int'(clk_lost), 1);
    chk("lost_nopv", pv_total - base, 0);

    // Recovery: first rise clears lost, second rise gives period_valid
    clk_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("rec_clr", int'(clk_lost), 0);
    repeat (45) @(negedge clk);
    clk_in = 1'b0;
    repeat (50) @(negedge clk);
    chk("rec_nopv", pv_total - base, 0);
    gen(50, 50);
    chk("rec_pv", pv_total - base, 1);
    chk("rec_cnt", last_pc, 100);

    // Reset when count has reached 50
    clk_in = 1'b1;
    repeat (50) @(negedge clk);
    clk_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_rst");
    reset = 1'b0;
    base = pv_total;
    repeat (46) @(negedge clk);
    gen(50, 50);
    chk("post_rst_pv0", pv_total - base, 0);
    gen(50, 50);
    chk("post_rst_pv1", pv_total - base, 1);
    chk("post_rst_cnt", last_pc, 100);
    chk("post_rst_ok", last_ok, 1);
    chk("post_rst_err", last_err, 0);

`ifdef CLK_MON_DUTY_EN
    gen(30, 70);
    gen(50, 50);
    chk("duty_high", last_hc, 30);
    chk("duty_cnt", last_pc, 100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
